dda_motion_sequencer: RTL

Two-axis segment sequencer for the stepper DDA datapath. Accepts line-segment commands (per-axis signed step count plus segment length in ticks) over a valid/ready handshake and buffers them in a 2-entry FIFO. Runs each segment as exactly `n` DDA ticks, emitting per-axis step and direction outputs. Handles limit switches, abort and back-to-back segments; sits between the motion command source and the axis driver pins.

---
 rtl/dda_pkg.sv | 20 ++
 rtl/dda_axis_acc.sv | 46 ++++
 rtl/dda_motion_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dda_pkg.sv
// Shared types and constants for the two-axis DDA segment sequencer.
package dda_pkg;

  localparam int ACC_W   = 9;
  localparam int DIR_BIT = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FAULT
  } state_t;

  typedef struct packed {
    logic [7:0] nx;
    logic [7:0] ny;
    logic [7:0] n;
  } cmd_t;

endpackage

// File: rtl/dda_axis_acc.sv
// One DDA axis: accumulates the step magnitude per tick and emits a
// registered step pulse each time the accumulator wraps past n.
module dda_axis_acc
  import dda_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       tick,
  input  logic [6:0] mag,
  input  logic [7:0] n,
  output logic       step
);

  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic             step_q, step_d;

  always_comb begin
    sum    = acc_q + {2'b00, mag};
    acc_d  = acc_q;
    step_d = 1'b0;
    if (clr) begin
      acc_d = '0;
    end else if (tick) begin
      if (sum >= {1'b0, n}) begin
        acc_d  = sum - {1'b0, n};
        step_d = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      step_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      step_q <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/dda_motion_sequencer.sv
// Two-axis DDA segment sequencer: 2-deep command FIFO, LOAD/RUN control and
// per-axis step generation, with limit-switch fault and abort handling.
module dda_motion_sequencer
  import dda_pkg::*;
#(
  parameter int TICK_DIV = 100,
  parameter int W        = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_nx,
  input  logic [W-1:0] cmd_ny,
  input  logic [W-1:0] cmd_n,
  input  logic         ls_x,
  input  logic         ls_y,
  input  logic         abort,
  input  logic         clr_fault,
  output logic         step_x,
  output logic         step_y,
  output logic         dir_x,
  output logic         dir_y,
  output logic         seg_done,
  output logic         busy,
  output logic         fault
);
  // state | meaning
  // IDLE  | waiting for a queued command
  // LOAD  | one cycle: pop head, latch it, clear accumulators and timers, validate
  // RUN   | prescaler running; n DDA ticks of stepping
  // FAULT | limit hit or magnitude > n; pushes blocked until clr_fault

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        state_q, state_d;
  cmd_t          ent0_q, ent0_d, ent1_q, ent1_d, cur_q, cur_d, new_cmd;
  logic [1:0]    cnt_q, cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    tick_cnt_q, tick_cnt_d;
  logic          seg_done_q, seg_done_d;
  logic          rdy_q, rdy_d;
  logic          push, pop, flush, ls_any, mag_fault, tick;

  assign new_cmd   = '{nx: cmd_nx, ny: cmd_ny, n: cmd_n};
  assign ls_any    = ls_x || ls_y;
  assign mag_fault = ({1'b0, ent0_q.nx[DIR_BIT-1:0]} > ent0_q.n) ||
                     ({1'b0, ent0_q.ny[DIR_BIT-1:0]} > ent0_q.n);
  assign cmd_ready = rdy_q && (cnt_q != 2'd2) && (state_q != S_FAULT);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_LOAD);
  assign flush     = abort ||
                     (((state_q == S_LOAD) || (state_q == S_RUN)) && ls_any) ||
                     ((state_q == S_LOAD) && mag_fault);
  assign tick      = (state_q == S_RUN) && (presc_q == PRESC_LAST) && !abort && !ls_any;
  assign rdy_d     = 1'b1;

  // Pop shifts entry 1 down; the push lands in the first free slot after the pop.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      if (pop) begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      if (push) begin
        if (cnt_d == 2'd0) ent0_d = new_cmd;
        else               ent1_d = new_cmd;
        cnt_d = cnt_d + 2'd1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    presc_d    = presc_q;
    tick_cnt_d = tick_cnt_q;
    seg_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cnt_d != 2'd0) state_d = S_LOAD;
      end
      S_LOAD: begin
        cur_d      = ent0_q;
        presc_d    = '0;
        tick_cnt_d = '0;
        if (abort)                    state_d = S_IDLE;
        else if (ls_any || mag_fault) state_d = S_FAULT;
        else if (ent0_q.n == 8'd0) begin
          seg_done_d = 1'b1;
          state_d    = (cnt_d != 2'd0) ? S_LOAD : S_IDLE;
        end else                      state_d = S_RUN;
      end
      S_RUN: begin
        if (abort)       state_d = S_IDLE;
        else if (ls_any) state_d = S_FAULT;
        else if (presc_q == PRESC_LAST) begin
          presc_d    = '0;
          tick_cnt_d = tick_cnt_q + 8'd1;
          if ((tick_cnt_q + 8'd1) == cur_q.n) begin
            seg_done_d = 1'b1;
            state_d    = (cnt_d != 2'd0) ? S_LOAD : S_IDLE;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      S_FAULT: begin
        if (clr_fault) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ent0_q     <= '0;
      ent1_q     <= '0;
      cur_q      <= '0;
      cnt_q      <= 2'd0;
      presc_q    <= '0;
      tick_cnt_q <= '0;
      seg_done_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      cur_q      <= cur_d;
      cnt_q      <= cnt_d;
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
      seg_done_q <= seg_done_d;
      rdy_q      <= rdy_d;
    end
  end

  dda_axis_acc u_acc_x (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == S_LOAD),
    .tick (tick),
    .mag  (cur_q.nx[DIR_BIT-1:0]),
    .n    (cur_q.n),
    .step (step_x)
  );

  dda_axis_acc u_acc_y (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == S_LOAD),
    .tick (tick),
    .mag  (cur_q.ny[DIR_BIT-1:0]),
    .n    (cur_q.n),
    .step (step_y)
  );

  assign dir_x    = cur_q.nx[DIR_BIT];
  assign dir_y    = cur_q.ny[DIR_BIT];
  assign seg_done = seg_done_q;
  assign busy     = (state_q == S_LOAD) || (state_q == S_RUN);
  assign fault    = (state_q == S_FAULT);

endmodule
